// File: rtl/obi_data_mem.sv
// OBI data-side responder: single-port byte-enabled word memory with a fixed
// response latency, an outstanding-transaction limit and forced grant stalls.
module obi_data_mem #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          RSP_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic        gnt_stall_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [3:0]  outstanding_o
);
    localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [29:0] WORDS   = 30'(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   offset;
    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          in_range;
    logic          accept;
    logic          retire;
    logic          unused_offset;
    logic [3:0]    outstanding;
    logic [3:0]    eff_outstanding;

    logic          pipe_valid [RSP_LATENCY];
    logic [31:0]   pipe_rdata [RSP_LATENCY];
    logic          pipe_err   [RSP_LATENCY];

    assign offset        = data_addr_i - BASE_ADDR;
    assign word_idx      = offset[31:2];
    assign mem_idx       = word_idx[AW-1:0];
    assign unused_offset = ^offset[1:0];
    assign in_range      = (data_addr_i >= BASE_ADDR) && (word_idx < WORDS);

    // The response being presented this cycle retires at the coming edge, so it
    // already frees its slot: grant reopens in the first rvalid cycle.
    assign retire          = data_rvalid_o;
    assign eff_outstanding = outstanding - {3'b000, retire};
    assign data_gnt_o      = data_req_i & ~gnt_stall_i & (eff_outstanding < MAX_OUT) & rst_n;
    assign accept          = data_req_i & data_gnt_o;

    always_ff @(posedge clk) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_rdata[i] <= 32'h0;
                pipe_err[i]   <= 1'b0;
            end
            outstanding <= 4'd0;
        end else begin
            // Stage 0 carries zeros for idle slots, writes and errors.
            pipe_valid[0] <= accept;
            pipe_rdata[0] <= (accept && !data_we_i && in_range) ? mem[mem_idx] : 32'h0;
            pipe_err[0]   <= accept && !in_range;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
            unique case ({accept, retire})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign data_rvalid_o = pipe_valid[RSP_LATENCY-1];
    assign data_rdata_o  = pipe_rdata[RSP_LATENCY-1];
    assign data_err_o    = pipe_err[RSP_LATENCY-1];
    assign outstanding_o = outstanding;

endmodule

// File: tb/tb_obi_data_mem.sv
// Scoreboard bench for obi_data_mem: three instances with latencies 1, 3 and 4,
// exercised one at a time; expected responses are queued at grant time.
module tb_obi_data_mem;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 64;
    localparam int          NI    = 3;
    localparam int          LAT [NI] = '{1, 3, 4};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] req, we, stall, gnt, rvalid, err;
    logic [31:0]   addr [NI];
    logic [31:0]   wdata [NI];
    logic [31:0]   rdata [NI];
    logic [3:0]    be [NI];
    logic [3:0]    outst [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        obi_data_mem #(
            .MEM_WORDS(WORDS),
            .BASE_ADDR(BASE),
            .RSP_LATENCY(LAT[g]),
            .MAX_OUTSTANDING(2)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .data_req_i(req[g]),
            .data_addr_i(addr[g]),
            .data_we_i(we[g]),
            .data_be_i(be[g]),
            .data_wdata_i(wdata[g]),
            .gnt_stall_i(stall[g]),
            .data_gnt_o(gnt[g]),
            .data_rvalid_o(rvalid[g]),
            .data_rdata_o(rdata[g]),
            .data_err_o(err[g]),
            .outstanding_o(outst[g])
        );
    end

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e_pop;
    logic [31:0] mdl [int];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          cur = 0;
    int          t_start;
    int          n_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, inst %0d)", tag, obs, expv, cyc, cur);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid[cur]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid[cur]), 64'd0);
            end else begin
                e_pop = exp_q.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(e_pop.cyc));
                check("rsp_rdata", 64'(rdata[cur]), 64'(e_pop.rdata));
                check("rsp_err", 64'(err[cur]), 64'(e_pop.err));
            end
        end else begin
            check("idle_rsp_zero", 64'({err[cur], rdata[cur]}), 64'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just before the accept edge: update model, queue expected response.
    task automatic expect_acc(input logic w, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        exp_t        e;
        logic        ok;
        int          idx;
        logic [31:0] old;
        ok    = (a >= BASE) && (((a - BASE) >> 2) < WORDS);
        idx   = int'((a - BASE) >> 2);
        old   = mdl.exists(idx) ? mdl[idx] : 32'h0;
        e.cyc   = cyc + LAT[cur];
        e.err   = !ok;
        e.rdata = (ok && !w) ? old : 32'h0;
        if (ok && w) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) old[8*i +: 8] = d[8*i +: 8];
            end
            mdl[idx] = old;
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        int waited = 0;
        req[cur] = 1'b1; we[cur] = w; addr[cur] = a; be[cur] = b; wdata[cur] = d;
        #1;
        while (!gnt[cur] && waited < 40) begin
            tick(1);
            waited++;
        end
        if (!gnt[cur]) begin
            check("gnt_timeout", 64'(gnt[cur]), 64'd1);
            req[cur] = 1'b0;
        end else begin
            expect_acc(w, a, b, d);
            tick(1);
        end
    endtask

    task automatic drain();
        int waited = 0;
        req[cur] = 1'b0;
        we[cur]  = 1'b0;
        while (exp_q.size() != 0 && waited < 30) begin
            tick(1);
            waited++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        tick(2);
    endtask

    initial begin
        req = '1; we = '0; stall = '0;
        for (int i = 0; i < NI; i++) begin
            addr[i] = BASE; wdata[i] = 32'h0; be[i] = 4'h0;
        end
        tick(2);
        check("rst_gnt", 64'(gnt), 64'd0);
        for (int i = 0; i < NI; i++) begin
            check("rst_outst", 64'(outst[i]), 64'd0);
            check("rst_rdata", 64'(rdata[i]), 64'd0);
        end
        check("rst_rvalid", 64'(rvalid), 64'd0);
        req = '0;
        rst_n = 1'b1;
        tick(2);

        // Write/merge/read, back-to-back at latency 1
        cur = 0;
        t_start = cyc;
        issue(1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b1, BASE + 32'h10, 4'b0001, 32'h000000AA);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        issue(1'b1, BASE + 32'h10, 4'b0000, 32'h12345678);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        issue(1'b1, BASE + 32'h10, 4'b0110, 32'h11223344);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        check("btb_cycles", 64'(cyc - t_start), 64'd7);
        drain();

        // Stalled write must not land; stalled read is accepted on release
        stall[0] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h10; be[0] = 4'hF; wdata[0] = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_gnt", 64'(gnt[0]), 64'd0);
            tick(1);
        end
        req[0] = 1'b0; stall[0] = 1'b0;
        tick(1);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        drain();
        stall[0] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h10;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_rd_gnt", 64'(gnt[0]), 64'd0);
            tick(1);
        end
        stall[0] = 1'b0;
        #1;
        check("stall_release_gnt", 64'(gnt[0]), 64'd1);
        if (gnt[0]) expect_acc(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        tick(1);
        drain();

        // Out-of-range accesses above and below the window
        issue(1'b1, BASE, 4'hF, 32'h11111111);
        issue(1'b1, BASE + 4*(WORDS-1), 4'hF, 32'h22222222);
        issue(1'b0, BASE + 4*WORDS, 4'h0, 32'h0);
        issue(1'b1, BASE + 4*WORDS, 4'hF, 32'hFFFFFFFF);
        issue(1'b1, BASE - 4, 4'hF, 32'hEEEEEEEE);
        issue(1'b0, BASE - 4, 4'h0, 32'h0);
        issue(1'b0, BASE, 4'h0, 32'h0);
        issue(1'b0, BASE + 4*(WORDS-1), 4'h0, 32'h0);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        drain();

        // Latency 3: single read timing, then in-order back-to-back reads
        cur = 1;
        mdl.delete();
        issue(1'b1, BASE + 32'h0, 4'hF, 32'hA0A0A0A0);
        issue(1'b1, BASE + 32'h4, 4'hF, 32'hA1A1A1A1);
        issue(1'b1, BASE + 32'h8, 4'hF, 32'hA2A2A2A2);
        drain();
        issue(1'b0, BASE + 32'h4, 4'h0, 32'h0);
        drain();
        issue(1'b0, BASE + 32'h0, 4'h0, 32'h0);
        issue(1'b0, BASE + 32'h4, 4'h0, 32'h0);
        issue(1'b0, BASE + 32'h8, 4'h0, 32'h0);
        drain();

        // Outstanding limit with req held high
        n_acc = 0;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0;
        for (int c = 0; c < 8; c++) begin
            addr[1] = BASE + 32'(4 * (n_acc % 3));
            #1;
            check("lim_gnt", 64'(gnt[1]), (c < 2) ? 64'd1 : 64'((c % 3) != 2));
            check("lim_outst", 64'(outst[1]), (c == 0) ? 64'd0 : (c == 1) ? 64'd1 : 64'd2);
            if (gnt[1]) begin
                expect_acc(1'b0, addr[1], 4'h0, 32'h0);
                n_acc++;
            end
            tick(1);
        end
        check("lim_accepts", 64'(n_acc), 64'd6);
        drain();

        // Reset with two reads in flight at latency 4
        cur = 2;
        mdl.delete();
        issue(1'b1, BASE + 32'h20, 4'hF, 32'h5A5A1234);
        issue(1'b1, BASE + 32'h24, 4'hF, 32'h0BADCAFE);
        drain();
        issue(1'b0, BASE + 32'h20, 4'h0, 32'h0);
        issue(1'b0, BASE + 32'h24, 4'h0, 32'h0);
        req[2] = 1'b0;
        check("pre_rst_outst", 64'(outst[2]), 64'd2);
        exp_q.delete();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("post_rst_outst", 64'(outst[2]), 64'd0);
        check("post_rst_rvalid", 64'(rvalid[2]), 64'd0);
        tick(8);
        check("post_rst_outst_late", 64'(outst[2]), 64'd0);
        issue(1'b0, BASE + 32'h20, 4'h0, 32'h0);
        issue(1'b0, BASE + 32'h24, 4'h0, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
